uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Byte queue plus handshake sequencer directly upstream of the UART transmit path.
- Accepts bytes from the CPU/bus side into a FIFO and presents them one at a time on the transmit path's data/enable inputs.
- Paces each byte on the transmit path's done flag.
- Decouples bursty writers from the 11-bit-per-byte serial rate.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16).
- EN_HOLD, 8, cycles uart_tx_en_o is held high per byte. Must be ≥4 to cover the TX path's 3-flop enable synchroniser.
- TIMEOUT_CYC, 65535, max cycles spent waiting on done per phase before abandoning the byte. Counter width is 17 bits.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- wr_data_i  in  8  byte to queue
- wr_en_i  in  1  write strobe, one byte per cycle high
- full_o  out  1  FIFO full
- empty_o  out  1  FIFO empty
- level_o  out  DEPTH_LOG2+1  FIFO occupancy, 0..2**DEPTH_LOG2
- ovf_o  out  1  one-cycle pulse: write dropped because FIFO full
- uart_tx_data_o  out  8  byte to TX path
- uart_tx_en_o  out  1  transmit enable to TX path (rising edge starts a frame)
- uart_tx_done_i  in  1  done flag from TX path. Low while sending, high when idle after a frame. Low after power-up before the first frame.
- busy_o  out  1  high whenever FSM is not IDLE
- timeout_o  out  1  one-cycle pulse: handshake timed out, byte dropped

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers 0, level_o=0, empty_o=1, full_o=0.
  - ovf_o=0, uart_tx_data_o=8'h00, uart_tx_en_o=0, busy_o=0, timeout_o=0, FSM=IDLE.
  - Reset mid-byte drops the byte and any queued data. uart_tx_en_o goes low immediately.
- FIFO:
  - Registered storage; write pointer and read pointer wrap modulo 2**DEPTH_LOG2.
  - Occupancy is tracked by a (DEPTH_LOG2+1)-bit counter.
  - Write when full is ignored and pulses ovf_o the next cycle, even if a pop occurs in the same cycle.
  - Write and pop in the same cycle with FIFO neither full nor empty: level unchanged.
  - Write to an empty FIFO: entry becomes visible (empty_o=0) the next cycle.
- FSM:
  - IDLE: if !empty_o, pop head into uart_tx_data_o, load hold counter = EN_HOLD-1, go STROBE.
  - STROBE: uart_tx_en_o=1. Decrement counter; at 0 drop en and go WAIT_LOW, clearing the timeout counter.
  - WAIT_LOW: wait for uart_tx_done_i==0 (TX path has started). Already low at power-up is acceptable. Go WAIT_HIGH and clear the timeout counter.
  - WAIT_HIGH: wait for uart_tx_done_i==1 (frame complete), then go IDLE. The next byte can pop in the following cycle.
  - In WAIT_LOW or WAIT_HIGH, if the timeout counter reaches TIMEOUT_CYC: pulse timeout_o and go IDLE. The byte is lost; the FIFO is unaffected.
- Data stability:
  - uart_tx_data_o changes only on the IDLE→STROBE transition.
  - It is held stable through STROBE, WAIT_LOW and WAIT_HIGH.
- Latency:
  - wr_en_i into an empty FIFO with FSM in IDLE gives uart_tx_en_o high 2 cycles later (1 cycle FIFO write, 1 cycle pop/launch).
- Spacing: en is low for at least 1 cycle between bytes, so the TX path always sees a fresh rising edge.
- busy_o = (state != IDLE).
- Writes are accepted in every state.

Test Plan:
- Reset then single byte: write 8'hA5, TX model drives done low 4 cycles after en rise and high 11 bit-times later -> uart_tx_en_o high exactly 8 cycles starting 2 cycles after write; uart_tx_data_o=8'hA5 stable until done rises; busy_o falls the cycle after done rises.
- Burst: write 8'h01..8'h10 back-to-back (16 bytes) -> full_o=1 after the 16th, level_o=16; model receives bytes 01..10 in order; empty_o=1 after the last pop.
- Overflow: fill 16 entries, write 8'hFF while full -> ovf_o pulses once, level_o stays 16, 8'hFF is never transmitted.
- Power-up done-low: done held 0 from reset, write 8'h3C -> FSM passes WAIT_LOW immediately, waits in WAIT_HIGH until done=1, then returns to IDLE.
- Timeout: done stuck 1, TIMEOUT_CYC=100 -> timeout_o pulses 100 cycles after entering WAIT_LOW; the next queued byte launches the following cycle.
- Reset mid-transfer: assert rst_n_i low during WAIT_HIGH with 3 bytes queued -> uart_tx_en_o=0, level_o=0, busy_o=0 asynchronously; nothing further is launched after release.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding the UART transmit path one byte at a time, pacing each
// byte on the TX path's done flag with a per-phase timeout.
module uart_tx_feeder #(
   parameter int DEPTH_LOG2  = 4,
   parameter int EN_HOLD     = 8,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [7:0]            wr_data_i,
   input  logic                  wr_en_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  ovf_o,
   output logic [7:0]            uart_tx_data_o,
   output logic                  uart_tx_en_o,
   input  logic                  uart_tx_done_i,
   output logic                  busy_o,
   output logic                  timeout_o
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int HOLD_W = $clog2(EN_HOLD + 1);
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL   = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [HOLD_W-1:0]   HOLD_LOAD    = HOLD_W'(EN_HOLD - 1);
   localparam logic [16:0]         TIMEOUT_LAST = 17'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STROBE,
      ST_WAIT_LOW,
      ST_WAIT_HIGH
   } state_t;

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wrPtr_q;
   logic [DEPTH_LOG2-1:0] rdPtr_q;
   logic [DEPTH_LOG2:0]   level_q;
   logic [DEPTH_LOG2:0]   level_d;
   logic                  ovf_q;
   logic                  push;
   logic                  pop;

   state_t                state_q;
   logic [HOLD_W-1:0]     holdCnt_q;
   logic [16:0]           toCnt_q;
   logic [7:0]            txData_q;
   logic                  txEn_q;
   logic                  busy_q;
   logic                  timeout_q;

   assign full_o         = (level_q == FULL_LEVEL);
   assign empty_o        = (level_q == '0);
   assign level_o        = level_q;
   assign ovf_o          = ovf_q;
   assign uart_tx_data_o = txData_q;
   assign uart_tx_en_o   = txEn_q;
   assign busy_o         = busy_q;
   assign timeout_o      = timeout_q;

   // A write while full is dropped even if the FSM pops in the same cycle.
   assign push = wr_en_i && !full_o;
   assign pop  = (state_q == ST_IDLE) && !empty_o;

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wrPtr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         level_q <= level_d;
         ovf_q   <= wr_en_i && full_o;
      end
   end

   // Timeout counter restarts at each handshake phase and fires on its last count.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         holdCnt_q <= '0;
         toCnt_q   <= '0;
         txData_q  <= 8'h00;
         txEn_q    <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  txData_q  <= mem_q[rdPtr_q];
                  holdCnt_q <= HOLD_LOAD;
                  txEn_q    <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               if (holdCnt_q == '0) begin
                  txEn_q  <= 1'b0;
                  toCnt_q <= '0;
                  state_q <= ST_WAIT_LOW;
               end else begin
                  holdCnt_q <= holdCnt_q - 1'b1;
               end
            end
            ST_WAIT_LOW: begin
               if (!uart_tx_done_i) begin
                  toCnt_q <= '0;
                  state_q <= ST_WAIT_HIGH;
               end else if (toCnt_q == TIMEOUT_LAST) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else begin
                  toCnt_q <= toCnt_q + 1'b1;
               end
            end
            ST_WAIT_HIGH: begin
               if (uart_tx_done_i) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (toCnt_q == TIMEOUT_LAST) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else begin
                  toCnt_q <= toCnt_q + 1'b1;
               end
            end
            default: begin
               txEn_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: expected bytes are queued at write time
// and popped by a monitor at every rising edge of uart_tx_en_o.
module tb_uart_tx_feeder;

   localparam int BIT_CYC = 4;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic [7:0] wr_data_i;
   logic       wr_en_i;
   logic       full_o;
   logic       empty_o;
   logic [4:0] level_o;
   logic       ovf_o;
   logic [7:0] uart_tx_data_o;
   logic       uart_tx_en_o;
   logic       uart_tx_done_i;
   logic       busy_o;
   logic       timeout_o;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] expQ[$];
   bit         modelOn = 1'b0;
   int         launches = 0;
   int         ovfPulses = 0;
   int         toPulses = 0;

   uart_tx_feeder #(
      .DEPTH_LOG2  (4),
      .EN_HOLD     (8),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .wr_data_i      (wr_data_i),
      .wr_en_i        (wr_en_i),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .level_o        (level_o),
      .ovf_o          (ovf_o),
      .uart_tx_data_o (uart_tx_data_o),
      .uart_tx_en_o   (uart_tx_en_o),
      .uart_tx_done_i (uart_tx_done_i),
      .busy_o         (busy_o),
      .timeout_o      (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Called at a negedge; back-to-back calls give consecutive write cycles.
   task automatic applyStimulus(input logic [7:0] data, input bit expectSent);
      wr_data_i = data;
      wr_en_i   = 1'b1;
      if (expectSent) expQ.push_back(data);
      @(negedge clk_i);
      wr_en_i = 1'b0;
   endtask

   task automatic waitForEn(input logic level, input string name);
      int k = 0;
      while (uart_tx_en_o !== level && k < 300) begin
         @(negedge clk_i);
         k++;
      end
      checkOutput(name, uart_tx_en_o, level);
   endtask

   task automatic waitIdle(input string name);
      int k = 0;
      while ((busy_o !== 1'b0 || expQ.size() != 0) && k < 3000) begin
         @(negedge clk_i);
         k++;
      end
      checkOutput(name, busy_o, 0);
   endtask

   // TX path model: done low 4 cycles after en rises, high 11 bit-times later.
   initial begin
      forever begin
         @(posedge uart_tx_en_o);
         if (modelOn) begin
            repeat (4) @(negedge clk_i);
            uart_tx_done_i = 1'b0;
            repeat (11 * BIT_CYC) @(negedge clk_i);
            uart_tx_done_i = 1'b1;
            @(posedge clk_i);
            #1;
            checkOutput("busyFallAfterDone", busy_o, 0);
         end
      end
   end

   initial begin
      logic       enPrev;
      logic       busyPrev;
      logic       changed;
      logic [7:0] cur;
      int         enLen;
      enPrev = 1'b0; busyPrev = 1'b0; changed = 1'b0; cur = 8'h00; enLen = 0;
      forever begin
         @(negedge clk_i);
         if (rst_n_i !== 1'b1) begin
            enPrev = 1'b0; busyPrev = 1'b0; changed = 1'b0; enLen = 0;
            continue;
         end
         if (ovf_o) ovfPulses++;
         if (timeout_o) toPulses++;
         if (uart_tx_en_o && !enPrev) begin
            launches++;
            enLen   = 0;
            changed = 1'b0;
            cur     = uart_tx_data_o;
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedLaunch: actual=%0h expected=none", uart_tx_data_o);
            end else begin
               checkOutput("txData", uart_tx_data_o, expQ.pop_front());
            end
         end
         if (uart_tx_en_o) enLen++;
         if (!uart_tx_en_o && enPrev) checkOutput("enHoldLen", enLen, 8);
         if (busy_o && uart_tx_data_o !== cur) changed = 1'b1;
         if (!busy_o && busyPrev) checkOutput("dataStable", changed, 0);
         enPrev   = uart_tx_en_o;
         busyPrev = busy_o;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=expired expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      int launchesAtReset;
      wr_en_i        = 1'b0;
      wr_data_i      = 8'h00;
      uart_tx_done_i = 1'b0;
      rst_n_i        = 1'b0;
      repeat (3) @(negedge clk_i);
      checkOutput("rstLevel", level_o, 0);
      checkOutput("rstEmpty", empty_o, 1);
      checkOutput("rstFull", full_o, 0);
      checkOutput("rstOvf", ovf_o, 0);
      checkOutput("rstData", uart_tx_data_o, 8'h00);
      checkOutput("rstEn", uart_tx_en_o, 0);
      checkOutput("rstBusy", busy_o, 0);
      checkOutput("rstTimeout", timeout_o, 0);
      rst_n_i = 1'b1;
      repeat (2) @(negedge clk_i);

      $display("[TB] power-up done-low");
      applyStimulus(8'h3C, 1'b1);
      waitForEn(1'b1, "enRise3C");
      waitForEn(1'b0, "enFall3C");
      repeat (20) @(negedge clk_i);
      checkOutput("busyInWaitHigh", busy_o, 1);
      checkOutput("noTimeoutPowerUp", toPulses, 0);
      uart_tx_done_i = 1'b1;
      @(posedge clk_i);
      #1;
      checkOutput("busyFallPowerUp", busy_o, 0);
      @(negedge clk_i);
      modelOn = 1'b1;
      repeat (3) @(negedge clk_i);

      $display("[TB] single byte");
      applyStimulus(8'hA5, 1'b1);
      checkOutput("enLatency", uart_tx_en_o, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         checkOutput("enHighA5", uart_tx_en_o, 1);
         checkOutput("dataA5", uart_tx_data_o, 8'hA5);
      end
      @(negedge clk_i);
      checkOutput("enLowA5", uart_tx_en_o, 0);
      waitIdle("idleAfterA5");
      repeat (2) @(negedge clk_i);

      $display("[TB] burst and overflow");
      applyStimulus(8'h00, 1'b1);
      for (int i = 1; i <= 16; i++) applyStimulus(8'(i), 1'b1);
      checkOutput("burstLevel", level_o, 16);
      checkOutput("burstFull", full_o, 1);
      applyStimulus(8'hFF, 1'b0);
      checkOutput("ovfPulse", ovf_o, 1);
      checkOutput("ovfLevel", level_o, 16);
      @(negedge clk_i);
      checkOutput("ovfPulseEnd", ovf_o, 0);
      waitIdle("idleAfterBurst");
      checkOutput("burstEmpty", empty_o, 1);
      checkOutput("burstLevelZero", level_o, 0);
      repeat (2) @(negedge clk_i);

      $display("[TB] timeout");
      modelOn = 1'b0;
      applyStimulus(8'h55, 1'b1);
      applyStimulus(8'h66, 1'b1);
      waitForEn(1'b0, "enFall55");
      cyc = 0;
      while (!timeout_o && cyc < 300) begin
         @(negedge clk_i);
         cyc++;
      end
      checkOutput("timeoutDelay", cyc, 100);
      modelOn = 1'b1;
      @(negedge clk_i);
      checkOutput("timeoutPulseWidth", timeout_o, 0);
      checkOutput("launchAfterTimeout", uart_tx_en_o, 1);
      waitIdle("idleAfterTimeout");
      repeat (2) @(negedge clk_i);

      $display("[TB] reset mid-transfer");
      applyStimulus(8'hC1, 1'b1);
      applyStimulus(8'hC2, 1'b1);
      applyStimulus(8'hC3, 1'b1);
      applyStimulus(8'hC4, 1'b1);
      waitForEn(1'b0, "enFallC1");
      repeat (10) @(negedge clk_i);
      checkOutput("busyBeforeReset", busy_o, 1);
      checkOutput("levelBeforeReset", level_o, 3);
      #2;
      rst_n_i = 1'b0;
      expQ.delete();
      #1;
      checkOutput("asyncRstEn", uart_tx_en_o, 0);
      checkOutput("asyncRstLevel", level_o, 0);
      checkOutput("asyncRstBusy", busy_o, 0);
      checkOutput("asyncRstEmpty", empty_o, 1);
      launchesAtReset = launches;
      repeat (3) @(negedge clk_i);
      rst_n_i = 1'b1;
      repeat (120) @(negedge clk_i);
      checkOutput("noLaunchAfterReset", launches, launchesAtReset);
      checkOutput("levelAfterReset", level_o, 0);
      checkOutput("busyAfterReset", busy_o, 0);

      checkOutput("ovfPulseCount", ovfPulses, 1);
      checkOutput("timeoutPulseCount", toPulses, 1);
      checkOutput("totalLaunches", launches, 22);
      checkOutput("scoreboardEmpty", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
